ma_sched_ctrl: RTL and testbench

Sequencer for the multiply-accumulate array: walks the output-channel, pixel and input-channel group loops of one conv tile. It generates feature- and weight-buffer read addresses and asserts the array's compute-valid aligned to buffer read data. It also emits first/last accumulation tags aligned to the array's output-valid, so the downstream accumulator knows when to clear and when to flush. Issue is gated by a credit counter that mirrors free space in the downstream accumulator FIFO.

---
 rtl/ma_sched_ctrl_pkg.sv | 20 ++
 rtl/ma_sched_ctrl_if.sv | 44 ++++
 rtl/ma_sched_ctrl_tag_dly.sv | 25 ++
 rtl/ma_sched_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ma_sched_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ma_sched_ctrl_pkg.sv
// Shared types and latency constants for the MAC-array tile sequencer.
package ma_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int RD_LAT_DEF = 2;
  localparam int MA_LAT_DEF = 19;
  localparam int TAG_DLY    = RD_LAT_DEF + MA_LAT_DEF + 1;

  // Issue-to-accumulator-tag distance for a given buffer/array latency pair.
  function automatic int tag_dly(input int rd_lat, input int ma_lat);
    return rd_lat + ma_lat + 1;
  endfunction

endpackage

// File: rtl/ma_sched_ctrl_if.sv
// Config, credit and buffer/array signal bundle of the tile sequencer.
interface ma_sched_ctrl_if #(
  parameter int AW    = 12,
  parameter int CNT_W = 8
) ();
  import ma_sched_pkg::*;

  // I_start is a one-cycle request, accepted only while idle (no ready).
  // I_credit_ret pulses once per freed downstream beat. Read enables and
  // compute-valid are plain valid strobes: the consumer has no backpressure.
  logic             I_start;
  logic [CNT_W-1:0] I_cin_m1;
  logic [CNT_W-1:0] I_pix_m1;
  logic [CNT_W-1:0] I_cout_m1;
  logic [AW-1:0]    I_fbase;
  logic [AW-1:0]    I_wbase;
  logic             I_credit_ret;

  logic             O_frd_en;
  logic [AW-1:0]    O_faddr;
  logic             O_wrd_en;
  logic [AW-1:0]    O_waddr;
  logic             O_cpt_dv;
  logic             O_acc_first;
  logic             O_acc_last;
  logic             O_busy;
  logic             O_done;

  state_e           dbg_state;
  logic [15:0]      dbg_credits;

  modport master (
    input  I_start, I_cin_m1, I_pix_m1, I_cout_m1, I_fbase, I_wbase, I_credit_ret,
    output O_frd_en, O_faddr, O_wrd_en, O_waddr, O_cpt_dv, O_acc_first,
           O_acc_last, O_busy, O_done, dbg_state, dbg_credits
  );

  modport slave (
    output I_start, I_cin_m1, I_pix_m1, I_cout_m1, I_fbase, I_wbase, I_credit_ret,
    input  O_frd_en, O_faddr, O_wrd_en, O_waddr, O_cpt_dv, O_acc_first,
           O_acc_last, O_busy, O_done, dbg_state, dbg_credits
  );

endinterface

// File: rtl/ma_sched_ctrl_tag_dly.sv
// Fixed-depth shift-register delay line with asynchronous clear.
module ma_tag_dly #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         I_clk,
  input  logic         I_rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/ma_sched_ctrl.sv
// Conv-tile sequencer: walks cin/pix/cout loops, drives buffer reads and
// emits compute-valid plus accumulator first/last tags under credit control.
module ma_sched_ctrl
  import ma_sched_pkg::*;
#(
  parameter int AW      = 12,
  parameter int CNT_W   = 8,
  parameter int RD_LAT  = 2,
  parameter int MA_LAT  = 19,
  parameter int CREDITS = 16
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  ma_sched_ctrl_if.master bus
);

  localparam int TD  = tag_dly(RD_LAT, MA_LAT);
  localparam int CRW = $clog2(CREDITS + 1);
  localparam int IFW = $clog2(TD + 2) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cin_m1_q, pix_m1_q, cout_m1_q;
  logic [AW-1:0]    fbase_q, wbase_q;
  logic [CNT_W-1:0] cin_q, pix_q, cout_q;
  logic [AW-1:0]    frow_q, wrow_q;
  logic [CRW-1:0]   credits_q;
  logic [IFW-1:0]   infl_q, infl_d;
  logic             frd_en_q;
  logic [AW-1:0]    faddr_q, waddr_q;
  logic             acc_first_q, acc_last_q;

  logic             start_acc, iss, last_beat, exit_v, cpt_dv;
  logic             cin_end, pix_end, cout_end;
  logic [AW-1:0]    cin_step;
  logic [2:0]       tag_in, tag_out;

  assign start_acc = (state_q == IDLE) && bus.I_start;
  assign cin_end   = (cin_q == cin_m1_q);
  assign pix_end   = (pix_q == pix_m1_q);
  assign cout_end  = (cout_q == cout_m1_q);
  assign last_beat = cin_end && pix_end && cout_end;
  assign iss       = (state_q == ISSUE) && (credits_q != '0);
  assign cin_step  = AW'(cin_m1_q) + AW'(1);
  assign exit_v    = tag_out[2];
  assign tag_in    = {iss, iss & (cin_q == '0), iss & cin_end};

  always_comb begin
    infl_d = infl_q;
    if (iss && !exit_v)      infl_d = infl_q + IFW'(1);
    else if (!iss && exit_v) infl_d = infl_q - IFW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.I_start) state_d = ISSUE;
      ISSUE:   if (iss && last_beat) state_d = DRAIN;
      DRAIN:   if (infl_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
    end
  end

  // Loop walk: row offsets replace pix*(cin_m1+1) and cout*(cin_m1+1).
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cin_m1_q  <= '0;
      pix_m1_q  <= '0;
      cout_m1_q <= '0;
      fbase_q   <= '0;
      wbase_q   <= '0;
      cin_q     <= '0;
      pix_q     <= '0;
      cout_q    <= '0;
      frow_q    <= '0;
      wrow_q    <= '0;
    end else if (start_acc) begin
      cin_m1_q  <= bus.I_cin_m1;
      pix_m1_q  <= bus.I_pix_m1;
      cout_m1_q <= bus.I_cout_m1;
      fbase_q   <= bus.I_fbase;
      wbase_q   <= bus.I_wbase;
      cin_q     <= '0;
      pix_q     <= '0;
      cout_q    <= '0;
      frow_q    <= '0;
      wrow_q    <= '0;
    end else if (iss) begin
      if (cin_end) begin
        cin_q <= '0;
        if (pix_end) begin
          pix_q  <= '0;
          frow_q <= '0;
          cout_q <= cout_q + CNT_W'(1);
          wrow_q <= wrow_q + cin_step;
        end else begin
          pix_q  <= pix_q + CNT_W'(1);
          frow_q <= frow_q + cin_step;
        end
      end else begin
        cin_q <= cin_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      credits_q <= CRW'(CREDITS);
    end else if (iss && !bus.I_credit_ret) begin
      credits_q <= credits_q - CRW'(1);
    end else if (!iss && bus.I_credit_ret && credits_q != CRW'(CREDITS)) begin
      credits_q <= credits_q + CRW'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      frd_en_q    <= 1'b0;
      faddr_q     <= '0;
      waddr_q     <= '0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      frd_en_q    <= iss;
      acc_first_q <= tag_out[2] & tag_out[1];
      acc_last_q  <= tag_out[2] & tag_out[0];
      if (iss) begin
        faddr_q <= fbase_q + frow_q + AW'(cin_q);
        waddr_q <= wbase_q + wrow_q + AW'(cin_q);
      end
    end
  end

  ma_tag_dly #(.W(1), .DEPTH(RD_LAT)) u_dv_dly (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .d       (frd_en_q),
    .q       (cpt_dv)
  );

  // Fed one cycle before the registered enables; the output register on the
  // tags restores alignment, and the raw exit lets DONE coincide with the
  // last tag.
  ma_tag_dly #(.W(3), .DEPTH(TD)) u_tag_dly (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .d       (tag_in),
    .q       (tag_out)
  );

  assign bus.O_frd_en    = frd_en_q;
  assign bus.O_wrd_en    = frd_en_q;
  assign bus.O_faddr     = faddr_q;
  assign bus.O_waddr     = waddr_q;
  assign bus.O_cpt_dv    = cpt_dv;
  assign bus.O_acc_first = acc_first_q;
  assign bus.O_acc_last  = acc_last_q;
  assign bus.O_busy      = (state_q != IDLE);
  assign bus.O_done      = (state_q == DONE);
  assign bus.dbg_state   = state_q;
  assign bus.dbg_credits = 16'(credits_q);

endmodule

// File: tb/tb_ma_sched_ctrl.sv
// Directed bench for ma_sched_ctrl: address/tag scoreboard plus latency,
// credit, restart and reset-abort scenarios.
module tb_ma_sched_ctrl;
  import ma_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ma_sched_ctrl_if #(.AW(12), .CNT_W(8)) bus ();

  ma_sched_ctrl #(
    .AW(12), .CNT_W(8), .RD_LAT(2), .MA_LAT(19), .CREDITS(16)
  ) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus.master)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int iss_total = 0;
  int busy_total = 0;
  int last_iss_cyc = 0;

  logic [25:0] exp_q[$];
  logic [33:0] tag_q[$];
  int          cpt_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [25:0] beat(input logic [11:0] fa, input logic [11:0] wa,
                                       input logic f, input logic l);
    return {fa, wa, f, l};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon
    logic [25:0] e;
    logic [33:0] t;
    logic        due, ef, el, tdue;
    int          junk;
    if (bus.O_busy) busy_total++;
    if (!rst_n) begin
      tag_q.delete();
      cpt_q.delete();
    end else begin
      if (bus.O_frd_en) begin
        iss_total++;
        last_iss_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_issue", 32'(bus.O_faddr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("faddr", 32'(bus.O_faddr), 32'(e[25:14]));
          chk("waddr", 32'(bus.O_waddr), 32'(e[13:2]));
          chk("wrd_en", 32'(bus.O_wrd_en), 1);
          tag_q.push_back({32'(cyc + 22), e[1:0]});
          cpt_q.push_back(cyc + 2);
        end
      end else if (bus.O_wrd_en) begin
        chk("wrd_en_alone", 32'(bus.O_wrd_en), 0);
      end
      due = 1'b0;
      if (cpt_q.size() > 0 && cpt_q[0] == cyc) begin
        due = 1'b1;
        junk = cpt_q.pop_front();
      end
      if (due || bus.O_cpt_dv) chk("cpt_dv", 32'(bus.O_cpt_dv), 32'(due));
      tdue = 1'b0; ef = 1'b0; el = 1'b0;
      if (tag_q.size() > 0) begin
        t = tag_q[0];
        if (t[33:2] == 32'(cyc)) begin
          tdue = 1'b1; ef = t[1]; el = t[0];
          t = tag_q.pop_front();
        end
      end
      if (tdue || bus.O_acc_first || bus.O_acc_last) begin
        chk("acc_first", 32'(bus.O_acc_first), 32'(ef));
        chk("acc_last", 32'(bus.O_acc_last), 32'(el));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_tile(input logic [7:0] c, input logic [7:0] p, input logic [7:0] o,
                            input logic [11:0] fb, input logic [11:0] wb);
    @(posedge clk); #1;
    bus.I_cin_m1 = c; bus.I_pix_m1 = p; bus.I_cout_m1 = o;
    bus.I_fbase = fb; bus.I_wbase = wb; bus.I_start = 1'b1;
    @(posedge clk); #1;
    bus.I_start = 1'b0;
  endtask

  task automatic push_tile(input int c, input int p, input int o,
                           input logic [11:0] fb, input logic [11:0] wb);
    for (int co = 0; co <= o; co++)
      for (int pi = 0; pi <= p; pi++)
        for (int ci = 0; ci <= c; ci++)
          exp_q.push_back(beat(12'(fb + pi * (c + 1) + ci), 12'(wb + co * (c + 1) + ci),
                               ci == 0, ci == c));
  endtask

  task automatic ret_pulse();
    @(posedge clk); #1 bus.I_credit_ret = 1'b1;
    @(posedge clk); #1 bus.I_credit_ret = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int at;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.O_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk({tag, "_done_timeout"}, 0, 1);
    else chk({tag, "_done_dly"}, 32'(at - last_iss_cyc), 22);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(bus.O_done), 0);
    chk({tag, "_busy_low"}, 32'(bus.O_busy), 0);
    chk({tag, "_exp_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b0, i0;
    logic saw;
    rst_n = 1'b0;
    bus.I_start = 1'b0; bus.I_cin_m1 = '0; bus.I_pix_m1 = '0; bus.I_cout_m1 = '0;
    bus.I_fbase = '0; bus.I_wbase = '0; bus.I_credit_ret = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.O_busy), 0);
    chk("rst_frd_en", 32'(bus.O_frd_en), 0);
    chk("rst_cpt_dv", 32'(bus.O_cpt_dv), 0);
    chk("rst_acc_first", 32'(bus.O_acc_first), 0);
    chk("rst_acc_last", 32'(bus.O_acc_last), 0);
    chk("rst_done", 32'(bus.O_done), 0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("rst_credits", 32'(bus.dbg_credits), 16);
    @(posedge clk); #1 rst_n = 1'b1;

    // 3x2x1 tile, hand-computed addresses and tags
    exp_q.push_back(beat(12'h010, 12'h040, 1'b1, 1'b0));
    exp_q.push_back(beat(12'h011, 12'h041, 1'b0, 1'b0));
    exp_q.push_back(beat(12'h012, 12'h042, 1'b0, 1'b1));
    exp_q.push_back(beat(12'h013, 12'h040, 1'b1, 1'b0));
    exp_q.push_back(beat(12'h014, 12'h041, 1'b0, 1'b0));
    exp_q.push_back(beat(12'h015, 12'h042, 1'b0, 1'b1));
    start_tile(8'd2, 8'd1, 8'd0, 12'h010, 12'h040);
    wait_done("t1");
    chk("t1_credits", 32'(bus.dbg_credits), 10);

    repeat (6) ret_pulse();
    @(negedge clk);
    chk("cred_refill", 32'(bus.dbg_credits), 16);
    ret_pulse();
    @(negedge clk);
    chk("cred_saturate", 32'(bus.dbg_credits), 16);

    // single beat: both tags, busy window
    exp_q.push_back(beat(12'h123, 12'h456, 1'b1, 1'b1));
    b0 = busy_total;
    start_tile(8'd0, 8'd0, 8'd0, 12'h123, 12'h456);
    wait_done("t2");
    chk("t2_busy_cycles", 32'(busy_total - b0), 24);
    chk("t2_credits", 32'(bus.dbg_credits), 15);

    // returns coincide with every issue
    push_tile(2, 0, 0, 12'h080, 12'h090);
    start_tile(8'd2, 8'd0, 8'd0, 12'h080, 12'h090);
    bus.I_credit_ret = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.I_credit_ret = 1'b0;
    wait_done("t3");
    chk("cred_simul", 32'(bus.dbg_credits), 15);

    // restart attempt mid-tile, faddr wraps past 0xFFF
    push_tile(2, 1, 1, 12'hFFC, 12'h7F0);
    start_tile(8'd2, 8'd1, 8'd1, 12'hFFC, 12'h7F0);
    repeat (3) @(posedge clk);
    #1;
    bus.I_cin_m1 = 8'd0; bus.I_pix_m1 = 8'd0; bus.I_cout_m1 = 8'd0;
    bus.I_fbase = 12'h000; bus.I_wbase = 12'h000; bus.I_start = 1'b1;
    @(posedge clk); #1 bus.I_start = 1'b0;
    wait_done("t4");
    chk("t4_credits", 32'(bus.dbg_credits), 3);

    // credit stall: 4 credits for an 8-beat tile
    ret_pulse();
    push_tile(1, 1, 1, 12'h020, 12'h300);
    i0 = iss_total;
    start_tile(8'd1, 8'd1, 8'd1, 12'h020, 12'h300);
    repeat (30) @(negedge clk);
    chk("stall_issues", 32'(iss_total - i0), 4);
    chk("stall_state", 32'(bus.dbg_state), 32'(ISSUE));
    chk("stall_credits", 32'(bus.dbg_credits), 0);
    chk("stall_frd_en", 32'(bus.O_frd_en), 0);
    for (int k = 0; k < 4; k++) begin
      ret_pulse();
      repeat (6) @(negedge clk);
      chk("release_issue", 32'(iss_total - i0), 32'(5 + k));
    end
    wait_done("t5");

    // reset during ISSUE abandons the tile
    push_tile(2, 1, 1, 12'h400, 12'h500);
    start_tile(8'd2, 8'd1, 8'd1, 12'h400, 12'h500);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy", 32'(bus.O_busy), 0);
    chk("abort_cpt_dv", 32'(bus.O_cpt_dv), 0);
    chk("abort_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("abort_credits", 32'(bus.dbg_credits), 16);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.O_done || bus.O_cpt_dv || bus.O_acc_first || bus.O_acc_last) saw = 1'b1;
    end
    chk("abort_quiet", 32'(saw), 0);

    // fresh tile after the abort
    push_tile(2, 1, 0, 12'h010, 12'h040);
    start_tile(8'd2, 8'd1, 8'd0, 12'h010, 12'h040);
    wait_done("t7");
    chk("t7_credits", 32'(bus.dbg_credits), 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
